matmult_seq: RTL and testbench
==============================

Name: matmult_seq

Overview:
- Parametrised, time-multiplexed NxN matrix multiplier, C = A*B or C = C + A*B, using a single multiply-accumulate (MAC) unit.
- Operands arrive as a valid/ready stream of (A, B) element pairs in row-major order. Results leave as a valid/ready stream of C elements in row-major order.
- Replaces fixed-size, fully parallel, one-cycle multipliers where area matters more than throughput. Sits between the operand-fetch and result-writeback stages of the numeric datapath.

Parameters:
- N, 3, matrix dimension; N >= 2.
- DW, 32, input element width.
- OW, 32, output element width and accumulator width; OW >= DW.
- SIGNED, 0, 1 = operands are two's complement and are sign-extended to OW; 0 = operands are zero-extended.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- in_a  in  DW  element A[r][c] of the current beat.
- in_b  in  DW  element B[r][c] of the current beat.
- in_accum  in  1  mode flag; sampled only on the first beat of a load; 1 = C += A*B.
- out_valid  out  1  out_c holds a valid result element.
- out_ready  in  1  consumer accepts out_c.
- out_c  out  OW  element C[r][c], row-major.
- out_last  out  1  high with the final element C[N-1][N-1].
- busy  out  1  high in COMP or OUT.

Behaviour:
- Storage: A and B arrays (N*N x DW each), C array (N*N x OW), accumulator acc (OW).
- Reset values: all outputs 0 except in_ready = 1. State = LOAD. All counters = 0. C array and acc = 0. A and B contents are don't-care. Saved mode flag = 0.
- A beat transfers when in_valid && in_ready. in_valid is ignored whenever in_ready = 0.
- FSM:
  - LOAD: in_ready = 1. Beat k (0..N*N-1) writes A[k] and B[k]. Beat 0 also latches in_accum. After beat N*N-1 the block enters COMP on the next cycle.
  - COMP: in_ready = 0; lasts exactly N^3 cycles, step t = 0..N^3-1, with i = t/(N*N), j = (t/N)%N, k = t%N.
    - On k = 0, acc is seeded with C[i][j] if the saved mode is 1, else 0.
    - Each cycle adds ext(A[i][k]) * ext(B[k][j]) to acc. The product and the sum are both taken mod 2^OW.
    - On k = N-1, the final sum is written to C[i][j].
    - On the cycle after t = N^3-1, the block enters OUT.
  - OUT: out_valid = 1 and out_c = C[m] for m = 0..N*N-1. m advances on out_valid && out_ready. out_last = 1 when m = N*N-1. When the last element is accepted, the block returns to LOAD; out_valid drops on the next cycle, in_ready = 1 on that cycle, and C is retained for a later accumulate.
- Stability: while out_valid && !out_ready, out_c and out_last hold their values.
- Latency: the first out_valid is asserted exactly N^3 + 1 cycles after the cycle in which the last operand beat is accepted.
- Accumulate mode: in_accum = 1 on the first beat after reset sums onto C = 0 and gives a plain product.
- Reset at any point, including mid-LOAD, COMP or OUT: the block returns immediately to the reset state. Any partial load or partial result is discarded and C is cleared.
- in_accum is ignored on every beat except beat 0.

Test Plan:
- Basic product: N=3, DW=OW=32, A = 1..9 row-major, B = 9..1, accum=0 -> out_c stream 30,24,18,84,69,54,138,114,90. out_last on the 9th element. First out_valid exactly 28 cycles after the last accepted beat.
- Accumulate: repeat the same load with accum=1 -> 60,48,36,168,138,108,276,228,180. A third load with accum=0 and A = identity, B = 9..1 -> 9..1.
- Wrap and extension:
  - N=3, DW=OW=32, A[0] = B[0] = 0x0001_0000, all other elements 0 -> C[0] = 0, all other elements 0.
  - DW=8, OW=20, all elements 0xFF, SIGNED=1 -> every C element = 3.
  - Same stimulus with SIGNED=0 -> every C element = 0x2FA03.
- Handshake stress:
  - Random in_valid gaps -> results unchanged.
  - out_ready low for 5 cycles on element 4 -> out_c holds 69 and out_valid stays high; no element is lost or duplicated.
  - in_valid held high during COMP/OUT -> no beats are accepted.
- Reset mid-operation: assert rst during COMP step 10 -> the next cycle shows in_ready=1, out_valid=0, busy=0. A subsequent accum=1 load of the basic product yields 30,24,...,90, confirming C was cleared.
- Sizes: N=2 and N=4 with random operands, checked against a software model, including back-to-back loads started on the cycle after the last result is accepted.

Source files
------------

// File: rtl/matmult_seq.sv
// Time-multiplexed NxN matrix multiplier (C = A*B or C += A*B) built around one MAC.
// Operand pairs stream in row-major order; C elements stream out row-major.
module matmult_seq #(
  parameter int N      = 3,
  parameter int DW     = 32,
  parameter int OW     = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_accum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_c,
  output logic          out_last,
  output logic          busy
);

  localparam int NN = N * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {LOAD, COMP, OUT} state_t;

  state_t        state;
  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [OW-1:0] c_mem [NN];
  logic [OW-1:0] acc;
  logic [MW-1:0] ld_idx;
  logic [MW-1:0] out_idx;
  logic [IW-1:0] ci, cj, ck;
  logic          mode;

  logic [MW-1:0] a_idx, b_idx, c_idx;
  logic [OW-1:0] prod, seed, sum;
  logic          k_last, j_last, i_last, ld_last, out_end;

  function automatic logic [OW-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED) return OW'($signed(x));
    else        return OW'(x);
  endfunction

  // Single MAC datapath: acc is reseeded on the first k of every (i,j) dot product.
  always_comb begin
    a_idx   = MW'(int'(ci) * N + int'(ck));
    b_idx   = MW'(int'(ck) * N + int'(cj));
    c_idx   = MW'(int'(ci) * N + int'(cj));
    prod    = ext(a_mem[a_idx]) * ext(b_mem[b_idx]);
    seed    = mode ? c_mem[c_idx] : '0;
    sum     = ((ck == '0) ? seed : acc) + prod;
    k_last  = (ck == IW'(N - 1));
    j_last  = (cj == IW'(N - 1));
    i_last  = (ci == IW'(N - 1));
    ld_last = (ld_idx == MW'(NN - 1));
    out_end = (out_idx == MW'(NN - 1));
  end

  // Operand storage needs no reset; stale contents are always overwritten by a full load.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      a_mem[ld_idx] <= in_a;
      b_mem[ld_idx] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      ld_idx    <= '0;
      out_idx   <= '0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      acc       <= '0;
      mode      <= 1'b0;
      for (int unsigned x = 0; x < NN; x++) c_mem[x] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (ld_idx == '0) mode <= in_accum;
            if (ld_last) begin
              ld_idx   <= '0;
              state    <= COMP;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end

        COMP: begin
          acc <= sum;
          if (k_last) begin
            c_mem[c_idx] <= sum;
            ck           <= '0;
            if (j_last) begin
              cj <= '0;
              ci <= i_last ? '0 : ci + 1'b1;
            end else begin
              cj <= cj + 1'b1;
            end
          end else begin
            ck <= ck + 1'b1;
          end
          // C[0][0] was finalised long before the last step, so it can be presented now.
          if (k_last && j_last && i_last) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_c     <= c_mem[0];
            out_last  <= 1'b0;
          end
        end

        OUT: begin
          if (out_ready) begin
            if (out_end) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_c     <= '0;
              out_idx   <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx  <= out_idx + 1'b1;
              out_c    <= c_mem[out_idx + 1'b1];
              out_last <= ((out_idx + 1'b1) == MW'(NN - 1));
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmult_seq.sv
// Scoreboard bench for matmult_seq: five parameterisations share one stimulus bus,
// a selector routes beats to one instance and a negedge monitor checks its output stream.
module tb_matmult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [31:0] ia, ib;
  logic        iacc;
  logic        ordy_man, ordy_rand, rnd_bit, ordy;
  logic [2:0]  sel;

  logic        rdy [5];
  logic        ov  [5];
  logic        ol  [5];
  logic        bz  [5];
  logic [31:0] oc  [5];
  logic [19:0] oc1, oc2;

  logic        rdy_s, ov_s, ol_s, bz_s;
  logic [31:0] oc_s;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  int          cyc = 0;
  logic [32:0] q[$];

  logic [31:0] va [16];
  logic [31:0] vb [16];
  logic [31:0] e9 [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  assign ordy  = ordy_rand ? rnd_bit : ordy_man;
  assign oc[1] = {12'h000, oc1};
  assign oc[2] = {12'h000, oc2};

  matmult_seq #(.N(3), .DW(32), .OW(32), .SIGNED(1'b0)) u_n3 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 3'd0), .in_ready(rdy[0]),
    .in_a(ia), .in_b(ib), .in_accum(iacc), .out_valid(ov[0]), .out_ready(ordy),
    .out_c(oc[0]), .out_last(ol[0]), .busy(bz[0]));

  matmult_seq #(.N(3), .DW(8), .OW(20), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 3'd1), .in_ready(rdy[1]),
    .in_a(ia[7:0]), .in_b(ib[7:0]), .in_accum(iacc), .out_valid(ov[1]), .out_ready(ordy),
    .out_c(oc1), .out_last(ol[1]), .busy(bz[1]));

  matmult_seq #(.N(3), .DW(8), .OW(20), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 3'd2), .in_ready(rdy[2]),
    .in_a(ia[7:0]), .in_b(ib[7:0]), .in_accum(iacc), .out_valid(ov[2]), .out_ready(ordy),
    .out_c(oc2), .out_last(ol[2]), .busy(bz[2]));

  matmult_seq #(.N(2), .DW(16), .OW(32), .SIGNED(1'b1)) u_n2 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 3'd3), .in_ready(rdy[3]),
    .in_a(ia[15:0]), .in_b(ib[15:0]), .in_accum(iacc), .out_valid(ov[3]), .out_ready(ordy),
    .out_c(oc[3]), .out_last(ol[3]), .busy(bz[3]));

  matmult_seq #(.N(4), .DW(16), .OW(32), .SIGNED(1'b0)) u_n4 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 3'd4), .in_ready(rdy[4]),
    .in_a(ia[15:0]), .in_b(ib[15:0]), .in_accum(iacc), .out_valid(ov[4]), .out_ready(ordy),
    .out_c(oc[4]), .out_last(ol[4]), .busy(bz[4]));

  always_comb begin
    rdy_s = rdy[0]; ov_s = ov[0]; ol_s = ol[0]; bz_s = bz[0]; oc_s = oc[0];
    case (sel)
      3'd1: begin rdy_s = rdy[1]; ov_s = ov[1]; ol_s = ol[1]; bz_s = bz[1]; oc_s = oc[1]; end
      3'd2: begin rdy_s = rdy[2]; ov_s = ov[2]; ol_s = ol[2]; bz_s = bz[2]; oc_s = oc[2]; end
      3'd3: begin rdy_s = rdy[3]; ov_s = ov[3]; ol_s = ol[3]; bz_s = bz[3]; oc_s = oc[3]; end
      3'd4: begin rdy_s = rdy[4]; ov_s = ov[4]; ol_s = ol[4]; bz_s = bz[4]; oc_s = oc[4]; end
      default: ;
    endcase
  end

  // Monitor: compare every presented element against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && ov_s) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %0h, nothing was expected", oc_s);
      end else begin
        if (oc_s !== q[0][31:0] || ol_s !== q[0][32]) begin
          miscompares++;
          $display("FAIL out_stream: got c=%0h last=%0b, expected c=%0h last=%0b",
                   oc_s, ol_s, q[0][31:0], q[0][32]);
        end
        if (ordy) begin
          void'(q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_e9();
    for (int k = 0; k < 9; k++) q.push_back({(k == 8), e9[k]});
  endtask

  function automatic logic [31:0] extv(input logic [31:0] x, input int dw, input bit sgn);
    logic [31:0] m;
    m = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    extv = x & m;
    if (sgn && x[dw-1]) extv = extv | ~m;
  endfunction

  task automatic model_push(input int n, input int dw, input bit sgn);
    logic [31:0] s;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        s = '0;
        for (int k = 0; k < n; k++)
          s = s + extv(va[r*n+k], dw, sgn) * extv(vb[k*n+c], dw, sgn);
        q.push_back({(r == n-1 && c == n-1), s});
      end
  endtask

  // Beat k carries va[k]/vb[k]; in_accum is inverted on non-first beats to prove it is ignored.
  task automatic load(input int n, input logic acc, input bit gaps);
    int w;
    for (int k = 0; k < n*n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      iv = 1'b1; ia = va[k]; ib = vb[k];
      iacc = (k == 0) ? acc : ~acc;
      w = 0;
      while (!rdy_s && w < 2000) begin tick(); w++; end
      if (w >= 2000) begin
        vectors++; miscompares++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", w);
      end
      tick();
      iv = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (q.size() != 0 && w < 3000) begin tick(); w++; end
    if (w >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL %s_drain_timeout: got %0d pending, expected 0", name, q.size());
      q.delete();
    end
    check({name, "_ready_after"}, {31'd0, rdy_s}, 32'd1);
    check({name, "_valid_after"}, {31'd0, ov_s}, 32'd0);
    check({name, "_busy_after"},  {31'd0, bz_s}, 32'd0);
  endtask

  task automatic set_basic();
    for (int k = 0; k < 9; k++) begin va[k] = 32'(k + 1); vb[k] = 32'(9 - k); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    int base, ce, w;
    rst = 1'b1; iv = 1'b0; ia = '0; ib = '0; iacc = 1'b0;
    ordy_man = 1'b1; ordy_rand = 1'b0; sel = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    for (int u = 0; u < 5; u++) begin
      check("reset_in_ready",  {31'd0, rdy[u]}, 32'd1);
      check("reset_out_valid", {31'd0, ov[u]},  32'd0);
      check("reset_busy",      {31'd0, bz[u]},  32'd0);
      check("reset_out_c",     oc[u],           32'd0);
    end

    // Basic product, latency and a 5-cycle stall on element 4.
    set_basic();
    e9 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    push_e9();
    base = pops;
    load(3, 1'b0, 1'b0);
    ce = cyc; w = 0;
    while (!ov_s && w < 200) begin tick(); w++; end
    check("latency", 32'(cyc - ce + 1), 32'd28);
    w = 0;
    while (pops < base + 4 && w < 200) begin tick(); w++; end
    ordy_man = 1'b0;
    repeat (5) begin
      tick();
      check("stall_valid", {31'd0, ov_s}, 32'd1);
      check("stall_c", oc_s, 32'd69);
    end
    ordy_man = 1'b1;
    drain("basic");

    // Accumulate onto the previous result while in_valid stays high through COMP/OUT.
    e9 = '{60, 48, 36, 168, 138, 108, 276, 228, 180};
    push_e9();
    base = pops;
    load(3, 1'b1, 1'b0);
    iv = 1'b1; ia = 32'hDEAD_BEEF; ib = 32'h1234_5678;
    w = 0;
    while (w < 500) begin
      tick(); w++;
      if (pops >= base + 9) break;
      check("no_accept_busy", {31'd0, rdy_s}, 32'd0);
    end
    iv = 1'b0;
    drain("accum");

    // Product wraps mod 2^32.
    for (int k = 0; k < 9; k++) begin va[k] = '0; vb[k] = '0; end
    va[0] = 32'h0001_0000; vb[0] = 32'h0001_0000;
    e9 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    push_e9();
    load(3, 1'b0, 1'b0);
    drain("wrap");

    // Identity * B with in_valid gaps and random out_ready.
    for (int k = 0; k < 9; k++) begin va[k] = (k % 4 == 0) ? 32'd1 : 32'd0; vb[k] = 32'(9 - k); end
    e9 = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    push_e9();
    ordy_rand = 1'b1;
    load(3, 1'b0, 1'b1);
    drain("identity");
    ordy_rand = 1'b0;

    // Reset during COMP step 10 discards everything, including C.
    set_basic();
    load(3, 1'b0, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready",  {31'd0, rdy_s}, 32'd1);
    check("midrst_out_valid", {31'd0, ov_s},  32'd0);
    check("midrst_busy",      {31'd0, bz_s},  32'd0);
    e9 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    push_e9();
    load(3, 1'b1, 1'b0);
    drain("after_rst");

    // 8-bit operands, 20-bit result: signed vs unsigned extension.
    for (int k = 0; k < 9; k++) begin va[k] = 32'h0000_00FF; vb[k] = 32'h0000_00FF; end
    sel = 3'd1;
    e9 = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    push_e9();
    load(3, 1'b0, 1'b0);
    drain("signed8");
    sel = 3'd2;
    for (int k = 0; k < 9; k++) e9[k] = 32'h0002_FA03;
    push_e9();
    load(3, 1'b0, 1'b0);
    drain("unsigned8");

    // N=2 signed and N=4 unsigned, back-to-back loads, random handshakes.
    ordy_rand = 1'b1;
    sel = 3'd3;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin va[k] = $urandom & 32'hFFFF; vb[k] = $urandom & 32'hFFFF; end
      model_push(2, 16, 1'b1);
      load(2, 1'b0, r == 1);
    end
    drain("n2");
    sel = 3'd4;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) begin va[k] = $urandom & 32'hFFFF; vb[k] = $urandom & 32'hFFFF; end
      model_push(4, 16, 1'b0);
      load(4, 1'b0, r == 0);
    end
    drain("n4");
    ordy_rand = 1'b0;

    check("leftover_expected", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
